// File: rtl/gpu_span_sequencer.sv
// rtl/gpu_span_sequencer.sv - span-by-span GPU frame sequencer with buffered pixel stream.
// Optional RUN watchdog is built only when SEQ_TIMEOUT_EN is defined.
module gpu_span_sequencer #(
  parameter int          WIDTH     = 16,
  parameter int          WORD_SIZE = 16,
  parameter int          SPANS     = 64,
  parameter logic [15:0] END_PC    = 16'd255,
  parameter int          DRAIN_CYC = 4,
  parameter int          MAX_CYC   = 65535
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  output logic                         gpu_reset,
  input  logic [15:0]                  gpu_pc,
  input  logic [WIDTH*WORD_SIZE*3-1:0] gpu_frame,
  output logic [15:0]                  span_idx,
  output logic                         pix_valid,
  input  logic                         pix_ready,
  output logic [15:0]                  pix_addr,
  output logic [3*WORD_SIZE-1:0]       pix_data,
  output logic                         busy,
  output logic                         frame_done,
  output logic                         timeout_err
);

  localparam int PIX_W  = 3 * WORD_SIZE;
  localparam int LANE_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int SET_W  = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_RUN, S_SETTLE, S_CAPTURE, S_DRAIN, S_NEXT, S_DONE
  } state_t;

  state_t                   r_state;
  state_t                   w_next;
  logic [15:0]              r_span_idx;
  logic [LANE_W-1:0]        r_lane;
  logic [SET_W-1:0]         r_settle_cnt;
  logic                     r_run_armed;
  logic [WIDTH*PIX_W-1:0]   r_buf;
  logic                     w_end_hit;
  logic                     w_run_expire;
  logic                     w_zero_cap;
  logic                     w_last_lane;
  logic                     w_last_span;

  // The PC is ignored on the first RUN cycle: the core's fetch PC is still stale then.
  assign w_end_hit   = (r_state == S_RUN) && r_run_armed && (gpu_pc == END_PC);
  assign w_last_lane = (r_lane == LANE_W'(WIDTH - 1));
  assign w_last_span = (r_span_idx == 16'(SPANS - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start) w_next = S_LAUNCH;
      S_LAUNCH:  w_next = S_RUN;
      S_RUN: begin
        if (w_end_hit)         w_next = (DRAIN_CYC > 0) ? S_SETTLE : S_CAPTURE;
        else if (w_run_expire) w_next = S_CAPTURE;
      end
      S_SETTLE:  if (r_settle_cnt == SET_W'(DRAIN_CYC - 1)) w_next = S_CAPTURE;
      S_CAPTURE: w_next = S_DRAIN;
      S_DRAIN:   if (pix_ready && w_last_lane) w_next = S_NEXT;
      S_NEXT:    w_next = w_last_span ? S_DONE : S_LAUNCH;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_span_idx   <= '0;
      r_lane       <= '0;
      r_settle_cnt <= '0;
      r_run_armed  <= 1'b0;
      r_buf        <= '0;
    end else begin
      r_state      <= w_next;
      r_run_armed  <= (r_state == S_RUN);
      r_settle_cnt <= '0;
      case (r_state)
        S_IDLE:    if (start) r_span_idx <= '0;
        S_SETTLE:  r_settle_cnt <= r_settle_cnt + 1'b1;
        S_CAPTURE: begin
          r_buf  <= w_zero_cap ? '0 : gpu_frame;
          r_lane <= '0;
        end
        S_DRAIN:   if (pix_ready) r_lane <= r_lane + 1'b1;
        S_NEXT:    if (!w_last_span) r_span_idx <= r_span_idx + 16'd1;
        S_DONE:    r_span_idx <= '0;
        default:   ;
      endcase
    end
  end

`ifdef SEQ_TIMEOUT_EN
  localparam int RUN_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  logic [RUN_W-1:0] r_run_cnt;
  logic             r_timeout;
  logic             r_zero_cap;

  assign w_run_expire = (r_state == S_RUN) && (r_run_cnt == RUN_W'(MAX_CYC - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_run_cnt  <= '0;
      r_timeout  <= 1'b0;
      r_zero_cap <= 1'b0;
    end else begin
      r_run_cnt  <= (r_state == S_RUN) ? r_run_cnt + 1'b1 : '0;
      r_zero_cap <= w_run_expire && !w_end_hit;
      if ((r_state == S_IDLE) && start)    r_timeout <= 1'b0;
      else if (w_run_expire && !w_end_hit) r_timeout <= 1'b1;
    end
  end

  assign timeout_err = r_timeout;
  assign w_zero_cap  = r_zero_cap;
`else
  assign w_run_expire = 1'b0;
  assign w_zero_cap   = 1'b0;
  assign timeout_err  = 1'b0;
`endif

  // Stream fields are forced to zero outside DRAIN so idle/reset values are clean.
  assign pix_valid  = (r_state == S_DRAIN);
  assign pix_addr   = pix_valid ? (r_span_idx * 16'(WIDTH) + 16'(r_lane)) : 16'd0;
  assign pix_data   = pix_valid ? r_buf[int'(r_lane) * PIX_W +: PIX_W] : '0;
  assign gpu_reset  = !((r_state == S_RUN) || (r_state == S_SETTLE));
  assign busy       = (r_state != S_IDLE);
  assign frame_done = (r_state == S_DONE);
  assign span_idx   = r_span_idx;

endmodule

// File: tb/tb_gpu_span_sequencer.sv
// tb/tb_gpu_span_sequencer.sv - directed bench for gpu_span_sequencer (SPANS=2, default build).
module tb_gpu_span_sequencer;

  localparam int          WIDTH     = 16;
  localparam int          WORD_SIZE = 16;
  localparam int          SPANS     = 2;
  localparam int          PIX_W     = 3 * WORD_SIZE;
  localparam int          NPIX      = SPANS * WIDTH;
  localparam logic [15:0] END_PC    = 16'd255;

  typedef struct {
    int    ready_mode;
    int    pc_mode;
    int    exp_low;
    string name;
  } vec_t;

  logic                     clock = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     start = 1'b0;
  logic                     pix_ready = 1'b0;
  logic [15:0]              gpu_pc;
  logic [WIDTH*PIX_W-1:0]   gpu_frame;
  logic                     gpu_reset;
  logic [15:0]              span_idx;
  logic                     pix_valid;
  logic [15:0]              pix_addr;
  logic [PIX_W-1:0]         pix_data;
  logic                     busy;
  logic                     frame_done;
  logic                     timeout_err;

  int total = 0;
  int bad   = 0;
  int ready_mode = 0;
  int pc_mode    = 0;

  logic [15:0] run_cnt    = 16'd0;
  logic [15:0] gen        = 16'd1;
  logic        m_prev_rst = 1'b1;
  logic [15:0] cap_q[$];
  logic [15:0] xa_q[$];
  logic [47:0] xd_q[$];

  int          n_fall = 0;
  int          n_low  = 0;
  int          n_done = 0;
  int          stall_err = 0;
  logic        mn_prev_rst = 1'b1;
  logic        m_valid = 1'b0;
  logic        m_ready = 1'b0;
  logic [15:0] m_addr  = 16'd0;
  logic [47:0] m_data  = 48'd0;

  gpu_span_sequencer #(
    .WIDTH(WIDTH), .WORD_SIZE(WORD_SIZE), .SPANS(SPANS),
    .END_PC(END_PC), .DRAIN_CYC(4), .MAX_CYC(65535)
  ) dut (
    .clock(clock), .reset(rst_n), .start(start), .gpu_reset(gpu_reset),
    .gpu_pc(gpu_pc), .gpu_frame(gpu_frame), .span_idx(span_idx),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_addr(pix_addr),
    .pix_data(pix_data), .busy(busy), .frame_done(frame_done),
    .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  function automatic logic [47:0] pix_of(input logic [15:0] g, input int lane);
    logic [15:0] r;
    r = {g[7:0], 8'(lane)};
    return {r ^ 16'h5a5a, ~r, r};
  endfunction

  // GPU model: PC counts RUN cycles; frame content tracks a generation that steps right after capture.
  always_comb begin
    if (pc_mode == 1)          gpu_pc = END_PC;
    else if (run_cnt == 16'd9) gpu_pc = END_PC;
    else                       gpu_pc = run_cnt;
  end

  always_comb begin
    gpu_frame = '0;
    for (int i = 0; i < WIDTH; i++) gpu_frame[i*PIX_W +: PIX_W] = pix_of(gen, i);
  end

  always @(posedge clock) begin
    if (gpu_reset) run_cnt <= 16'd0;
    else           run_cnt <= run_cnt + 16'd1;
    if (gpu_reset && !m_prev_rst) begin
      cap_q.push_back(gen);
      gen <= gen + 16'd1;
    end
    m_prev_rst <= gpu_reset;
  end

  always @(negedge clock) begin
    if (!gpu_reset && mn_prev_rst) n_fall++;
    mn_prev_rst = gpu_reset;
    if (!gpu_reset) n_low++;
    if (frame_done) n_done++;
    if (m_valid && !m_ready && pix_valid && (pix_addr !== m_addr || pix_data !== m_data))
      stall_err++;
    if (pix_valid && pix_ready) begin
      xa_q.push_back(pix_addr);
      xd_q.push_back(pix_data);
    end
    m_valid = pix_valid;
    m_ready = pix_ready;
    m_addr  = pix_addr;
    m_data  = pix_data;
  end

  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (ready_mode == 0) pix_ready = 1'b1;
      else                 pix_ready = ~pix_ready;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_gpu_reset"}, gpu_reset, 1);
    chk({tag, "_span_idx"}, span_idx, 0);
    chk({tag, "_pix_valid"}, pix_valid, 0);
    chk({tag, "_pix_addr"}, pix_addr, 0);
    chk({tag, "_pix_data"}, pix_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_timeout_err"}, timeout_err, 0);
  endtask

  task automatic wait_done(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (frame_done) begin
        ok = 1'b1;
        break;
      end
    end
    chk({tag, "_done_seen"}, ok, 1);
  endtask

  task automatic check_frame(input string tag, input int bx, input int bc, input int npix);
    chk({tag, "_npix"}, xa_q.size() - bx, npix);
    for (int j = 0; j < npix; j++) begin
      if ((bx + j < xa_q.size()) && (bc + j / WIDTH < cap_q.size())) begin
        chk($sformatf("%s_addr%0d", tag, j), xa_q[bx+j], 16'(j % NPIX));
        chk($sformatf("%s_data%0d", tag, j), xd_q[bx+j], pix_of(cap_q[bc + j / WIDTH], j % WIDTH));
      end
    end
  endtask

  initial begin
    vec_t vecs[4];
    int   bx, bc, bd, bf, bl, bs;
    bit   ok;

    vecs[0] = '{0, 0, 28, "rdy1_pc10"};
    vecs[1] = '{1, 0, 28, "rdytog_pc10"};
    vecs[2] = '{0, 1, 12, "rdy1_pcnow"};
    vecs[3] = '{1, 1, 12, "rdytog_pcnow"};

    repeat (3) @(posedge clock);
    #1;
    chk_reset_vals("por");
    rst_n = 1'b1;
    tick();
    chk("idle_busy", busy, 0);
    chk("idle_gpu_reset", gpu_reset, 1);

    for (int v = 0; v < 4; v++) begin
      ready_mode = vecs[v].ready_mode;
      pc_mode    = vecs[v].pc_mode;
      bx = xa_q.size(); bc = cap_q.size(); bd = n_done; bf = n_fall; bl = n_low; bs = stall_err;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk({vecs[v].name, "_launch_busy"}, busy, 1);
      chk({vecs[v].name, "_launch_gpu_reset"}, gpu_reset, 1);
      chk({vecs[v].name, "_launch_span"}, span_idx, 0);
      wait_done(vecs[v].name);
      repeat (5) tick();
      chk({vecs[v].name, "_done_pulses"}, n_done - bd, 1);
      chk({vecs[v].name, "_gpu_runs"}, n_fall - bf, SPANS);
      chk({vecs[v].name, "_run_low_cycles"}, n_low - bl, vecs[v].exp_low);
      chk({vecs[v].name, "_captures"}, cap_q.size() - bc, SPANS);
      chk({vecs[v].name, "_stall_stable"}, stall_err - bs, 0);
      chk({vecs[v].name, "_end_busy"}, busy, 0);
      chk({vecs[v].name, "_timeout_err"}, timeout_err, 0);
      check_frame(vecs[v].name, bx, bc, NPIX);
    end

    // start pulsed while RUN must not disturb the frame
    ready_mode = 0; pc_mode = 0;
    bx = xa_q.size(); bc = cap_q.size(); bd = n_done;
    start = 1'b1;
    tick();
    start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (!gpu_reset) begin
        ok = 1'b1;
        break;
      end
    end
    chk("runstart_reach_run", ok, 1);
    start = 1'b1;
    repeat (3) tick();
    start = 1'b0;
    wait_done("runstart");
    repeat (40) tick();
    chk("runstart_done_pulses", n_done - bd, 1);
    chk("runstart_idle", busy, 0);
    check_frame("runstart", bx, bc, NPIX);

    // reset mid-DRAIN, then a clean restart
    start = 1'b1;
    tick();
    start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (pix_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk("rstmid_reach_drain", ok, 1);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rstmid");
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("rstmid_idle_busy", busy, 0);
    bx = xa_q.size(); bc = cap_q.size(); bd = n_done;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_busy", busy, 1);
    chk("restart_span", span_idx, 0);
    chk("restart_gpu_reset", gpu_reset, 1);
    tick();
    chk("restart_run", gpu_reset, 0);
    wait_done("restart");
    repeat (5) tick();
    chk("restart_done_pulses", n_done - bd, 1);
    check_frame("restart", bx, bc, NPIX);

    // start held high across DONE begins a second frame
    bx = xa_q.size(); bc = cap_q.size(); bd = n_done;
    start = 1'b1;
    wait_done("hold1");
    tick();
    chk("hold_idle_busy", busy, 0);
    tick();
    chk("hold_relaunch_busy", busy, 1);
    chk("hold_relaunch_span", span_idx, 0);
    start = 1'b0;
    wait_done("hold2");
    repeat (5) tick();
    chk("hold_done_pulses", n_done - bd, 2);
    check_frame("hold", bx, bc, 2 * NPIX);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gpu_span_sequencer.md
GPU_SPAN_SEQUENCER -- requirements
Module: gpu_span_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, lanes per span (matches gpu vector width).
REQ-002 SHALL have parameter WORD_SIZE, default 16, bits per colour channel.
REQ-003 SHALL have parameter SPANS, default 64, spans per frame (>=1).
REQ-004 SHALL have parameter END_PC, default 16'd255, program end address.
REQ-005 SHALL have parameter DRAIN_CYC, default 4, cycles waited after END_PC for pipeline writeback.
REQ-006 SHALL have parameter MAX_CYC, default 65535, RUN watchdog limit (used only with SEQ_TIMEOUT_EN).
REQ-007 SHALL have port clock  in  1  sole clock, all state on rising edge.
REQ-008 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-009 SHALL have port start  in  1  begin a frame; sampled only in IDLE.
REQ-010 SHALL have port gpu_reset  out  1  active-high reset to the gpu core.
REQ-011 SHALL have port gpu_pc  in  16  fetch PC from the gpu core.
REQ-012 SHALL have port gpu_frame  in  WIDTH*WORD_SIZE*3  per-lane RGB from the gpu core; lane i at [i*3*WORD_SIZE +: 3*WORD_SIZE].
REQ-013 SHALL have port span_idx  out  16  current span number, fed to the core as a scalar operand.
REQ-014 SHALL have ports pix_valid out 1, pix_ready in 1, pix_addr out 16, pix_data out 3*WORD_SIZE  pixel stream to the framebuffer.
REQ-015 SHALL have ports busy out 1, frame_done out 1 (one-cycle pulse), timeout_err out 1 (sticky).

Function
REQ-016 SHALL implement states IDLE, LAUNCH, RUN, SETTLE, CAPTURE, DRAIN, NEXT, DONE.
REQ-017 IDLE: gpu_reset=1, busy=0; start=1 -> LAUNCH with span_idx=0.
REQ-018 LAUNCH: exactly one cycle with gpu_reset=1, busy=1, then RUN.
REQ-019 RUN: gpu_reset=0; first gpu_pc compare no earlier than the 2nd RUN cycle; gpu_pc==END_PC -> SETTLE.
REQ-020 SETTLE: gpu_reset=0 for exactly DRAIN_CYC cycles, then CAPTURE.
REQ-021 CAPTURE: one cycle; latch all of gpu_frame into an internal buffer; gpu_reset=1 from this cycle on; -> DRAIN.
REQ-022 DRAIN: emit lanes 0..WIDTH-1 in order; pix_addr=span_idx*WIDTH+lane (mod 2^16); pix_data=buffered lane RGB.
REQ-023 Transfer SHALL occur only on pix_valid&&pix_ready; pix_addr/pix_data SHALL stay stable while pix_valid&&!pix_ready.
REQ-024 pix_valid SHALL not depend combinationally on pix_ready; back-to-back transfers SHALL sustain 1 pixel/cycle.
REQ-025 After the lane WIDTH-1 transfer -> NEXT; NEXT: span_idx==SPANS-1 -> DONE, else span_idx+1 and -> LAUNCH.
REQ-026 DONE: frame_done=1 for one cycle, span_idx returns to 0, -> IDLE.
REQ-027 start outside IDLE SHALL be ignored; start held high in IDLE after DONE SHALL begin a new frame.
REQ-028 busy SHALL be 1 in every state except IDLE.

Reset
REQ-029 reset low SHALL force IDLE immediately, mid-operation included, discarding the capture buffer.
REQ-030 Reset values: gpu_reset=1, span_idx=0, pix_valid=0, pix_addr=0, pix_data=0, busy=0, frame_done=0, timeout_err=0.

Configuration
REQ-031 With SEQ_TIMEOUT_EN defined, a RUN cycle counter SHALL, on reaching MAX_CYC without END_PC, set timeout_err, skip SETTLE, and enter CAPTURE with the buffer loaded with zeros.
REQ-032 timeout_err SHALL clear only on reset or on the next accepted start.
REQ-033 Without SEQ_TIMEOUT_EN, RUN SHALL wait indefinitely, no counter SHALL be built, and timeout_err SHALL be tied 0.

Verification
REQ-034 Reset low mid-DRAIN -> all outputs at REQ-030 values the same cycle; reset high then start -> span_idx=0 LAUNCH.
REQ-035 SPANS=2, gpu model hits END_PC on run cycle 10, pix_ready=1 -> 32 pixels, addr 0..31, one frame_done pulse, gpu_reset pulsed 2 times.
REQ-036 pix_ready toggled 1/0 each cycle -> pix_addr/pix_data unchanged across stalls, 16 transfers per span, no loss or duplication.
REQ-037 gpu_frame changed after CAPTURE -> drained data equals the captured values.
REQ-038 start pulsed during RUN -> no effect; frame completes normally.
REQ-039 SEQ_TIMEOUT_EN, MAX_CYC=20, gpu_pc never END_PC -> timeout_err=1 after 20 RUN cycles, 16 zero pixels, sequencer advances to next span.
